// File: rtl/despertador_mem_pkg.sv
// Shared constants and types for the despertador RAM arbiter.
// Geometry of the 1024x32 single-port program/data RAM.
package despertador_mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  localparam logic [ADDR_W-1:0] CLEAR_LAST = '1;

  typedef enum logic {
    ST_ARB,
    ST_CLEAR
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              cs;
    logic              we;
  } mem_cmd_t;

endpackage

// File: rtl/despertador_mem_arbiter_if.sv
// Avalon-MM master port bundle seen by the RAM arbiter.
// One instance per requesting master.
interface despertador_mem_arbiter_if;
  import despertador_mem_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address,
    output read,
    output write,
    output byteenable,
    output writedata,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  byteenable,
    input  writedata,
    output waitrequest,
    output readdata,
    output readdatavalid
  );

endinterface

// File: rtl/despertador_rr_arb2.sv
// Two-way round-robin grant; the pointer names the master that
// wins the next contended cycle and only moves on contention.
module despertador_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic ptr_q;
  logic ptr_d;
  logic contend;

  assign contend = en & req0 & req1;

  assign gnt0 = en & req0 & (~req1 | ~ptr_q);
  assign gnt1 = en & req1 & (~req0 |  ptr_q);

  assign ptr_d = contend ? ~ptr_q : ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/despertador_mem_arbiter.sv
// Round-robin sharing of the single-port RAM between two masters,
// with one-cycle read return and a whole-RAM zero-fill engine.
module despertador_mem_arbiter
  import despertador_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  despertador_mem_arbiter_if.slave m0,
  despertador_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              done_q;
  logic              done_d;

  logic req0;
  logic req1;
  logic arb_en;
  logic clr_act;
  logic gnt0;
  logic gnt1;
  logic rd0;
  logic rd1;

  logic              tag0_q;
  logic              tag1_q;
  logic [DATA_W-1:0] hold0_q;
  logic [DATA_W-1:0] hold1_q;

  mem_cmd_t cmd;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  assign arb_en  = ~reset & (state_q == ST_ARB);
  assign clr_act = ~reset & (state_q == ST_CLEAR);

  despertador_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  // A simultaneous read+write is treated as a write only.
  assign rd0 = gnt0 & m0.read & ~m0.write;
  assign rd1 = gnt1 & m1.read & ~m1.write;

  assign m0.waitrequest = ~gnt0;
  assign m1.waitrequest = ~gnt1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CLEAR_LAST) begin
          state_d = ST_ARB;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ARB;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    cmd = '0;
    unique case (1'b1)
      clr_act: begin
        cmd.addr  = cnt_q;
        cmd.be    = '1;
        cmd.wdata = '0;
        cmd.cs    = 1'b1;
        cmd.we    = 1'b1;
      end
      gnt0: begin
        cmd.addr  = m0.address;
        cmd.be    = m0.byteenable;
        cmd.wdata = m0.writedata;
        cmd.cs    = 1'b1;
        cmd.we    = m0.write;
      end
      gnt1: begin
        cmd.addr  = m1.address;
        cmd.be    = m1.byteenable;
        cmd.wdata = m1.writedata;
        cmd.cs    = 1'b1;
        cmd.we    = m1.write;
      end
      default: begin
        cmd = '0;
      end
    endcase
  end

  assign mem_address    = cmd.addr;
  assign mem_byteenable = cmd.be;
  assign mem_writedata  = cmd.wdata;
  assign mem_chipselect = cmd.cs;
  assign mem_write      = cmd.we;
  assign mem_clken      = 1'b1;

  // RAM q is only valid in the return cycle, so it is passed through
  // then and captured to hold the last value afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag0_q  <= 1'b0;
      tag1_q  <= 1'b0;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      tag0_q <= rd0;
      tag1_q <= rd1;
      if (tag0_q) begin
        hold0_q <= mem_readdata;
      end
      if (tag1_q) begin
        hold1_q <= mem_readdata;
      end
    end
  end

  assign m0.readdatavalid = tag0_q & ~reset;
  assign m1.readdatavalid = tag1_q & ~reset;

  assign m0.readdata = m0.readdatavalid ? mem_readdata : hold0_q;
  assign m1.readdata = m1.readdatavalid ? mem_readdata : hold1_q;

  assign clear_busy = (state_q == ST_CLEAR);
  assign clear_done = done_q;

endmodule
